// File: rtl/rx_byte_assembler_if.sv
// Byte-stream and frame-result signals between the I2C byte receiver,
// the byte assembler and the key register.
interface rx_byte_assembler_if #(
    parameter int NUM_BYTES = 16
);
    localparam int CNT_W = $clog2(NUM_BYTES + 1);

    logic                   start_det;
    logic                   stop_det;
    logic                   byte_valid;
    logic [7:0]             byte_in;
    logic [8*NUM_BYTES-1:0] rx_data;
    logic                   reg_enable;
    logic [CNT_W-1:0]       byte_count;
    logic                   frame_error;

    modport master (
        output start_det, stop_det, byte_valid, byte_in,
        input  rx_data, reg_enable, byte_count, frame_error
    );

    modport slave (
        input  start_det, stop_det, byte_valid, byte_in,
        output rx_data, reg_enable, byte_count, frame_error
    );
endinterface

// File: rtl/rx_byte_assembler.sv
// Assembles NUM_BYTES received I2C bytes MSB-first into one word and strobes
// reg_enable on a complete frame; flags short, overrun and aborted frames.
//
// state | meaning
// IDLE  | no frame open; bytes and STOP ignored
// RECV  | frame open, fewer than NUM_BYTES bytes accepted
// HOLD  | frame complete, waiting for STOP; extra bytes are overruns
module rx_byte_assembler #(
    parameter int NUM_BYTES = 16,
    parameter int CNT_W     = $clog2(NUM_BYTES + 1)
) (
    input logic              clk,
    input logic              n_rst,
    rx_byte_assembler_if.slave bus
);
    localparam int DW = 8 * NUM_BYTES;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RECV = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t           state, state_nxt;
    logic [DW-1:0]    data_q, data_nxt;
    logic [CNT_W-1:0] cnt_q, cnt_nxt;
    logic             en_q, en_nxt;
    logic             err_q, err_nxt;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state  <= IDLE;
            data_q <= '0;
            cnt_q  <= '0;
            en_q   <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            state  <= state_nxt;
            data_q <= data_nxt;
            cnt_q  <= cnt_nxt;
            en_q   <= en_nxt;
            err_q  <= err_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        data_nxt  = data_q;
        cnt_nxt   = cnt_q;
        en_nxt    = 1'b0;
        err_nxt   = 1'b0;

        case (state)
            IDLE: begin
                if (bus.start_det) begin
                    state_nxt = RECV;
                    data_nxt  = '0;
                    cnt_nxt   = '0;
                end
            end

            RECV: begin
                if (bus.start_det) begin
                    // restart discards the partial frame; it is an error only if bytes were lost
                    data_nxt = '0;
                    cnt_nxt  = '0;
                    err_nxt  = (cnt_q != '0);
                end else begin
                    if (bus.byte_valid) begin
                        data_nxt = {data_q[DW-9:0], bus.byte_in};
                        cnt_nxt  = cnt_q + CNT_W'(1);
                        if (cnt_q == CNT_W'(NUM_BYTES - 1)) begin
                            state_nxt = HOLD;
                            en_nxt    = 1'b1;
                        end
                    end
                    // STOP is judged against the count after any same-cycle byte
                    if (bus.stop_det) begin
                        state_nxt = IDLE;
                        err_nxt   = !en_nxt;
                    end
                end
            end

            HOLD: begin
                if (bus.start_det) begin
                    state_nxt = RECV;
                    data_nxt  = '0;
                    cnt_nxt   = '0;
                end else begin
                    if (bus.byte_valid) begin
                        err_nxt = 1'b1;
                    end
                    if (bus.stop_det) begin
                        state_nxt = IDLE;
                    end
                end
            end

            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    assign bus.rx_data     = data_q;
    assign bus.byte_count  = cnt_q;
    assign bus.reg_enable  = en_q;
    assign bus.frame_error = err_q;
endmodule

// File: tb/tb_rx_byte_assembler.sv
// Directed bench for rx_byte_assembler: full, short, overrun, restart,
// collision and mid-frame reset scenarios against hand-computed values.
module tb_rx_byte_assembler;
    logic clk = 1'b0;
    logic n_rst;
    int   checks   = 0;
    int   failures = 0;
    int   en_total  = 0;
    int   err_total = 0;

    rx_byte_assembler_if #(.NUM_BYTES(16)) bus ();

    rx_byte_assembler #(.NUM_BYTES(16)) dut (
        .clk   (clk),
        .n_rst (n_rst),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    // running totals of strobes seen on the outputs
    always @(posedge clk) begin
        if (bus.reg_enable)  en_total  <= en_total + 1;
        if (bus.frame_error) err_total <= err_total + 1;
    end

    task automatic drive(input logic s, input logic p, input logic v, input logic [7:0] b);
        @(negedge clk);
        bus.start_det  = s;
        bus.stop_det   = p;
        bus.byte_valid = v;
        bus.byte_in    = b;
        @(posedge clk);
        #1;
        bus.start_det  = 1'b0;
        bus.stop_det   = 1'b0;
        bus.byte_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_bytes(input logic [7:0] base, input int n, input int gap);
        for (int i = 0; i < n; i++) begin
            drive(1'b0, 1'b0, 1'b1, 8'(base + 8'(i)));
            idle(gap);
        end
    endtask

    task automatic test_reset;
        checks++; if (bus.rx_data !== 128'h0) begin failures++; $display("FAIL reset_rx_data got=%h exp=0", bus.rx_data); end
        checks++; if (bus.byte_count !== 5'd0) begin failures++; $display("FAIL reset_byte_count got=%0d exp=0", bus.byte_count); end
        checks++; if (bus.reg_enable !== 1'b0) begin failures++; $display("FAIL reset_reg_enable got=%b exp=0", bus.reg_enable); end
        checks++; if (bus.frame_error !== 1'b0) begin failures++; $display("FAIL reset_frame_error got=%b exp=0", bus.frame_error); end
    endtask

    task automatic test_full_frame;
        int en0, err0;
        idle(2);
        en0 = en_total; err0 = err_total;
        drive(1'b1, 1'b0, 1'b0, 8'h00);
        send_bytes(8'h00, 15, 3);
        checks++; if (bus.reg_enable !== 1'b0) begin failures++; $display("FAIL full_no_early_en got=%b exp=0", bus.reg_enable); end
        drive(1'b0, 1'b0, 1'b1, 8'h0F);
        checks++; if (bus.reg_enable !== 1'b1) begin failures++; $display("FAIL full_reg_enable got=%b exp=1", bus.reg_enable); end
        checks++; if (bus.rx_data !== 128'h000102030405060708090A0B0C0D0E0F) begin failures++; $display("FAIL full_rx_data got=%h exp=000102030405060708090a0b0c0d0e0f", bus.rx_data); end
        checks++; if (bus.byte_count !== 5'd16) begin failures++; $display("FAIL full_byte_count got=%0d exp=16", bus.byte_count); end
        idle(1);
        checks++; if (bus.reg_enable !== 1'b0) begin failures++; $display("FAIL full_en_width got=%b exp=0", bus.reg_enable); end
        idle(2);
        drive(1'b0, 1'b1, 1'b0, 8'h00);
        idle(2);
        checks++; if (en_total - en0 !== 1) begin failures++; $display("FAIL full_en_count got=%0d exp=1", en_total - en0); end
        checks++; if (err_total - err0 !== 0) begin failures++; $display("FAIL full_err_count got=%0d exp=0", err_total - err0); end
        checks++; if (bus.byte_count !== 5'd16) begin failures++; $display("FAIL full_count_hold got=%0d exp=16", bus.byte_count); end
    endtask

    task automatic test_short_frame;
        int en0;
        en0 = en_total;
        drive(1'b1, 1'b0, 1'b0, 8'h00);
        send_bytes(8'hA1, 5, 1);
        drive(1'b0, 1'b1, 1'b0, 8'h00);
        checks++; if (bus.frame_error !== 1'b1) begin failures++; $display("FAIL short_frame_error got=%b exp=1", bus.frame_error); end
        checks++; if (bus.byte_count !== 5'd5) begin failures++; $display("FAIL short_byte_count got=%0d exp=5", bus.byte_count); end
        checks++; if (bus.rx_data !== 128'hA1A2A3A4A5) begin failures++; $display("FAIL short_rx_data got=%h exp=a1a2a3a4a5", bus.rx_data); end
        idle(1);
        checks++; if (bus.frame_error !== 1'b0) begin failures++; $display("FAIL short_err_width got=%b exp=0", bus.frame_error); end
        drive(1'b0, 1'b0, 1'b1, 8'h77);
        checks++; if (bus.byte_count !== 5'd5) begin failures++; $display("FAIL short_idle_ignore got=%0d exp=5", bus.byte_count); end
        checks++; if (bus.frame_error !== 1'b0) begin failures++; $display("FAIL short_idle_no_err got=%b exp=0", bus.frame_error); end
        idle(2);
        checks++; if (en_total - en0 !== 0) begin failures++; $display("FAIL short_en_count got=%0d exp=0", en_total - en0); end
    endtask

    task automatic test_overrun;
        int en0, err0;
        en0 = en_total; err0 = err_total;
        drive(1'b1, 1'b0, 1'b0, 8'h00);
        for (int i = 0; i < 16; i++) drive(1'b0, 1'b0, 1'b1, 8'hFF);
        checks++; if (bus.reg_enable !== 1'b1) begin failures++; $display("FAIL ovr_reg_enable got=%b exp=1", bus.reg_enable); end
        idle(1);
        drive(1'b0, 1'b0, 1'b1, 8'h55);
        checks++; if (bus.frame_error !== 1'b1) begin failures++; $display("FAIL ovr_frame_error got=%b exp=1", bus.frame_error); end
        checks++; if (bus.rx_data !== {128{1'b1}}) begin failures++; $display("FAIL ovr_rx_data got=%h exp=all ones", bus.rx_data); end
        checks++; if (bus.byte_count !== 5'd16) begin failures++; $display("FAIL ovr_byte_count got=%0d exp=16", bus.byte_count); end
        drive(1'b0, 1'b1, 1'b0, 8'h00);
        idle(2);
        checks++; if (en_total - en0 !== 1) begin failures++; $display("FAIL ovr_en_count got=%0d exp=1", en_total - en0); end
        checks++; if (err_total - err0 !== 1) begin failures++; $display("FAIL ovr_err_count got=%0d exp=1", err_total - err0); end
    endtask

    task automatic test_restart;
        int en0, err0;
        en0 = en_total; err0 = err_total;
        drive(1'b1, 1'b0, 1'b0, 8'h00);
        send_bytes(8'h40, 7, 0);
        drive(1'b1, 1'b0, 1'b0, 8'h00);
        checks++; if (bus.frame_error !== 1'b1) begin failures++; $display("FAIL rst_frame_error got=%b exp=1", bus.frame_error); end
        checks++; if (bus.byte_count !== 5'd0) begin failures++; $display("FAIL rst_byte_count got=%0d exp=0", bus.byte_count); end
        checks++; if (bus.rx_data !== 128'h0) begin failures++; $display("FAIL rst_rx_data_clr got=%h exp=0", bus.rx_data); end
        send_bytes(8'h10, 16, 0);
        checks++; if (bus.rx_data !== 128'h101112131415161718191A1B1C1D1E1F) begin failures++; $display("FAIL rst_rx_data got=%h exp=101112131415161718191a1b1c1d1e1f", bus.rx_data); end
        drive(1'b0, 1'b1, 1'b0, 8'h00);
        idle(2);
        checks++; if (en_total - en0 !== 1) begin failures++; $display("FAIL rst_en_count got=%0d exp=1", en_total - en0); end
        checks++; if (err_total - err0 !== 1) begin failures++; $display("FAIL rst_err_count got=%0d exp=1", err_total - err0); end
    endtask

    task automatic test_collisions;
        drive(1'b1, 1'b0, 1'b0, 8'h00);
        send_bytes(8'h30, 15, 0);
        drive(1'b0, 1'b1, 1'b1, 8'h3F);
        checks++; if (bus.reg_enable !== 1'b1) begin failures++; $display("FAIL col_last_stop_en got=%b exp=1", bus.reg_enable); end
        checks++; if (bus.frame_error !== 1'b0) begin failures++; $display("FAIL col_last_stop_err got=%b exp=0", bus.frame_error); end
        checks++; if (bus.rx_data !== 128'h303132333435363738393A3B3C3D3E3F) begin failures++; $display("FAIL col_rx_data got=%h exp=303132333435363738393a3b3c3d3e3f", bus.rx_data); end
        // back in IDLE, so a further byte is neither an overrun nor shifted in
        drive(1'b0, 1'b0, 1'b1, 8'hEE);
        checks++; if (bus.frame_error !== 1'b0) begin failures++; $display("FAIL col_idle_after_stop got=%b exp=0", bus.frame_error); end
        drive(1'b1, 1'b0, 1'b1, 8'hAB);
        checks++; if (bus.byte_count !== 5'd0) begin failures++; $display("FAIL col_start_byte_cnt got=%0d exp=0", bus.byte_count); end
        checks++; if (bus.rx_data !== 128'h0) begin failures++; $display("FAIL col_start_byte_data got=%h exp=0", bus.rx_data); end
        drive(1'b0, 1'b1, 1'b1, 8'hC3);
        checks++; if (bus.frame_error !== 1'b1) begin failures++; $display("FAIL col_short_stop_err got=%b exp=1", bus.frame_error); end
        checks++; if (bus.rx_data !== 128'hC3) begin failures++; $display("FAIL col_short_stop_data got=%h exp=c3", bus.rx_data); end
        idle(2);
    endtask

    task automatic test_reset_mid;
        int en0, err0;
        en0 = en_total; err0 = err_total;
        drive(1'b1, 1'b0, 1'b0, 8'h00);
        send_bytes(8'h50, 9, 0);
        @(negedge clk);
        #2 n_rst = 1'b0;
        #1;
        checks++; if (bus.rx_data !== 128'h0) begin failures++; $display("FAIL mid_rst_rx_data got=%h exp=0", bus.rx_data); end
        checks++; if (bus.byte_count !== 5'd0) begin failures++; $display("FAIL mid_rst_byte_count got=%0d exp=0", bus.byte_count); end
        @(negedge clk);
        n_rst = 1'b1;
        idle(1);
        drive(1'b0, 1'b0, 1'b1, 8'h99);
        checks++; if (bus.byte_count !== 5'd0) begin failures++; $display("FAIL mid_rst_ignore got=%0d exp=0", bus.byte_count); end
        drive(1'b1, 1'b0, 1'b0, 8'h00);
        send_bytes(8'h20, 16, 1);
        idle(1);
        checks++; if (bus.rx_data !== 128'h202122232425262728292A2B2C2D2E2F) begin failures++; $display("FAIL mid_rst_frame got=%h exp=202122232425262728292a2b2c2d2e2f", bus.rx_data); end
        drive(1'b0, 1'b1, 1'b0, 8'h00);
        idle(2);
        checks++; if (en_total - en0 !== 1) begin failures++; $display("FAIL mid_rst_en_count got=%0d exp=1", en_total - en0); end
        checks++; if (err_total - err0 !== 0) begin failures++; $display("FAIL mid_rst_err_count got=%0d exp=0", err_total - err0); end
    endtask

    initial begin
        n_rst          = 1'b0;
        bus.start_det  = 1'b0;
        bus.stop_det   = 1'b0;
        bus.byte_valid = 1'b0;
        bus.byte_in    = 8'h00;
        #22;
        test_reset();
        @(negedge clk);
        n_rst = 1'b1;
        test_full_frame();
        test_short_frame();
        test_overrun();
        test_restart();
        test_collisions();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
